jtag_dtm_sampled: RTL and testbench
===================================

JTAG_DTM_SAMPLED -- requirements
Module: jtag_dtm_sampled

Interface
REQ-001 SHALL have parameter IDCODE, default 32'h1E200A6D, value shifted out by the IDCODE data register.
REQ-002 SHALL have parameter DMI_ABITS, default 6, DMI address width; DMI register width is DMI_ABITS+34.
REQ-003 SHALL have port clk  in  1  sole clock; all state updates on its rising edge.
REQ-004 SHALL have port rst  in  1  synchronous reset, active-low.
REQ-005 SHALL have port jtag_TCK  in  1  JTAG clock pin, asynchronous to clk and sampled as data.
REQ-006 SHALL have port jtag_TMS  in  1  JTAG mode select pin.
REQ-007 SHALL have port jtag_TDI  in  1  JTAG serial data in.
REQ-008 SHALL have port jtag_TDO  out  1  JTAG serial data out.
REQ-009 SHALL have port ir_reg  out  5  current instruction register.
REQ-010 SHALL have port dtm_req_valid  out  1  DMI request to debug module pending.
REQ-011 SHALL have port dtm_req_data  out  40  {addr[39:34], data[33:2], op[1:0]}.
REQ-012 SHALL have port dtm_req_ready  in  1  debug module accepts request.
REQ-013 SHALL have port dm_resp_valid  in  1  debug module response strobe, one clk.
REQ-014 SHALL have port dm_resp_data  in  32  read data returned with dm_resp_valid.

Function
REQ-015 SHALL synchronize TCK/TMS/TDI through 2 flops; TCK rise event = sync high and previous low; fall event is the inverse; min TCK half-period 4 clk.
REQ-016 SHALL implement the 16-state IEEE 1149.1 TAP FSM, advancing only on a TCK rise event using the synchronized TMS.
REQ-017 SHALL reach Test-Logic-Reset after 5 consecutive rise events with TMS=1 from any state.
REQ-018 In Test-Logic-Reset SHALL set ir_reg=5'h01 and clear sticky dmistat.
REQ-019 Capture-IR SHALL load IR shift register with 5'b00001; Shift-IR shifts right, TDI into bit 4; Update-IR copies it to ir_reg.
REQ-020 SHALL decode ir_reg: 0x01 IDCODE (32b), 0x10 DTMCS (32b), 0x11 DMI (40b), all others BYPASS (1b, captures 0).
REQ-021 Capture-DR SHALL load: IDCODE; DTMCS = {14'b0, 2'b0, 1'b0, idle=3'd5, dmistat[1:0], abits=6'd6, version=4'd1}; DMI = {6'b0, last_rdata[31:0], status}, status=2'b11 if request/response outstanding or sticky set, else 2'b00.
REQ-022 Shift-DR SHALL shift right on rise event, TDI into MSB of the selected length.
REQ-023 jtag_TDO SHALL update only on TCK fall events, to bit 0 of the active shift register in Shift-IR/Shift-DR, else hold; reset value 0.
REQ-024 Update-DR on DMI with op=01 or 10 and nothing outstanding SHALL set dtm_req_valid=1 and dtm_req_data=shift register on the next clk.
REQ-025 dtm_req_valid SHALL hold with stable data until the clk with dtm_req_ready=1, then clear; transaction stays outstanding until dm_resp_valid.
REQ-026 dm_resp_valid while outstanding SHALL store dm_resp_data into last_rdata and clear outstanding; dm_resp_valid otherwise is ignored.
REQ-027 Update-DR on DMI while outstanding SHALL drop the request and set sticky dmistat=2'b11; op=00 or 11 SHALL issue nothing.
REQ-028 Update-DR on DTMCS with bit16 (dmireset) SHALL clear sticky; bit17 (dmihardreset) SHALL also clear outstanding and dtm_req_valid.
REQ-029 dm_resp_valid and a new Update-DR in the same clk: response SHALL be processed first, request accepted.

Reset
REQ-030 rst=0 at a clk edge SHALL force TAP=Test-Logic-Reset, ir_reg=5'h01, jtag_TDO=0, dtm_req_valid=0, dtm_req_data=0, last_rdata=0, sticky=0, outstanding=0, shift registers=0, sync flops=0.
REQ-031 Reset mid-shift or with a request pending SHALL discard all partial state; no request is issued after release.

Verification
REQ-032 Reset, 8 TCK pulses TMS=1 -> TAP in Test-Logic-Reset, ir_reg=0x01, dtm_req_valid=0.
REQ-033 From Run-Test/Idle, Capture-DR, shift 32 bits with IR=IDCODE -> TDO bits LSB-first form 0x1E200A6D.
REQ-034 Shift IR=5'h11, Update-IR -> ir_reg=0x11; captured IR bits out = 5'b00001.
REQ-035 DMI shift {6'h10, 32'h0, 2'b10}, Update-DR, dtm_req_ready=0 for 10 clk then 1 -> dtm_req_valid high with data 40'h40_0000_0002 until ready, then low.
REQ-036 DMI read op=01 outstanding, second write issued before dm_resp_valid -> no second request, next DMI capture status=2'b11; DTMCS write bit16=1 plus dm_resp_valid with 32'hDEADBEEF -> next DMI capture = {6'b0, 32'hDEADBEEF, 2'b00}.
REQ-037 rst=0 asserted during Shift-DR of a DMI write -> after release, dtm_req_valid stays 0 and ir_reg=0x01.

Source files
------------

// File: rtl/jtag_dtm_sampled.sv
// jtag_dtm_sampled : JTAG debug transport module, single clock domain.
// The JTAG pins are oversampled on clk. TCK edges are recovered as one-clk
// events, and every piece of state (TAP, IR/DR, DMI handshake) updates on
// the rising edge of clk.
//
// Ports
//   clk            sole clock
//   rst            synchronous reset, active-low
//   jtag_TCK/TMS/TDI  JTAG pins, asynchronous to clk, sampled as data
//   jtag_TDO       serial data out, changes only on TCK fall events
//   ir_reg         current instruction register
//   dtm_req_valid/dtm_req_data/dtm_req_ready  DMI request to the debug module
//                  data = {addr, data[31:0], op[1:0]}
//   dm_resp_valid/dm_resp_data  one-clk read-data return from the debug module
module jtag_dtm_sampled #(
   parameter logic [31:0] IDCODE    = 32'h1E200A6D,
   parameter int unsigned DMI_ABITS = 6
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   jtag_TCK,
   input  logic                   jtag_TMS,
   input  logic                   jtag_TDI,
   output logic                   jtag_TDO,
   output logic [4:0]             ir_reg,
   output logic                   dtm_req_valid,
   output logic [DMI_ABITS+33:0]  dtm_req_data,
   input  logic                   dtm_req_ready,
   input  logic                   dm_resp_valid,
   input  logic [31:0]            dm_resp_data
);

   localparam int unsigned DMI_W = DMI_ABITS + 34;

   localparam logic [4:0] IR_IDCODE = 5'h01;
   localparam logic [4:0] IR_DTMCS  = 5'h10;
   localparam logic [4:0] IR_DMI    = 5'h11;

   typedef enum logic [3:0] {
      TLR      = 4'd0,  RTI      = 4'd1,  SEL_DR   = 4'd2,  CAP_DR   = 4'd3,
      SHIFT_DR = 4'd4,  EXIT1_DR = 4'd5,  PAUSE_DR = 4'd6,  EXIT2_DR = 4'd7,
      UPD_DR   = 4'd8,  SEL_IR   = 4'd9,  CAP_IR   = 4'd10, SHIFT_IR = 4'd11,
      EXIT1_IR = 4'd12, PAUSE_IR = 4'd13, EXIT2_IR = 4'd14, UPD_IR   = 4'd15
   } tap_e;

   // IEEE 1149.1 TAP transition table
   function automatic tap_e tap_next(input tap_e s, input logic tms);
      case (s)
         TLR:      tap_next = tms ? TLR      : RTI;
         RTI:      tap_next = tms ? SEL_DR   : RTI;
         SEL_DR:   tap_next = tms ? SEL_IR   : CAP_DR;
         CAP_DR:   tap_next = tms ? EXIT1_DR : SHIFT_DR;
         SHIFT_DR: tap_next = tms ? EXIT1_DR : SHIFT_DR;
         EXIT1_DR: tap_next = tms ? UPD_DR   : PAUSE_DR;
         PAUSE_DR: tap_next = tms ? EXIT2_DR : PAUSE_DR;
         EXIT2_DR: tap_next = tms ? UPD_DR   : SHIFT_DR;
         UPD_DR:   tap_next = tms ? SEL_DR   : RTI;
         SEL_IR:   tap_next = tms ? TLR      : CAP_IR;
         CAP_IR:   tap_next = tms ? EXIT1_IR : SHIFT_IR;
         SHIFT_IR: tap_next = tms ? EXIT1_IR : SHIFT_IR;
         EXIT1_IR: tap_next = tms ? UPD_IR   : PAUSE_IR;
         PAUSE_IR: tap_next = tms ? EXIT2_IR : PAUSE_IR;
         EXIT2_IR: tap_next = tms ? UPD_IR   : SHIFT_IR;
         UPD_IR:   tap_next = tms ? SEL_DR   : RTI;
         default:  tap_next = TLR;
      endcase
   endfunction

   logic [1:0]       tck_sync_q, tck_sync_d;
   logic [1:0]       tms_sync_q, tms_sync_d;
   logic [1:0]       tdi_sync_q, tdi_sync_d;
   logic             tck_prev_q, tck_prev_d;
   tap_e             state_q, state_d;
   logic [4:0]       ir_sr_q, ir_sr_d;
   logic [4:0]       ir_reg_q, ir_reg_d;
   logic [DMI_W-1:0] dr_sr_q, dr_sr_d;
   logic             tdo_q, tdo_d;
   logic             req_valid_q, req_valid_d;
   logic [DMI_W-1:0] req_data_q, req_data_d;
   logic [31:0]      rdata_q, rdata_d;
   logic [1:0]       sticky_q, sticky_d;
   logic             outst_q, outst_d;

   logic             tck_rise_s, tck_fall_s, tms_s, tdi_s;
   logic [1:0]       dmi_status_s;
   logic [31:0]      dtmcs_s;
   logic [DMI_W-1:0] dr_cap_s, dr_shift_s;

   // synchronized pin views and TCK edge events
   always_comb begin
      tms_s      = tms_sync_q[1];
      tdi_s      = tdi_sync_q[1];
      tck_rise_s = tck_sync_q[1] & ~tck_prev_q;
      tck_fall_s = ~tck_sync_q[1] & tck_prev_q;
   end

   // DR capture value and shifted value for the selected register length
   always_comb begin
      // outst_q also covers a request still waiting for dtm_req_ready
      dmi_status_s = (outst_q || (sticky_q != 2'b00)) ? 2'b11 : 2'b00;
      dtmcs_s      = {14'b0, 2'b00, 1'b0, 3'd5, sticky_q, 6'(DMI_ABITS), 4'd1};
      case (ir_reg_q)
         IR_IDCODE: begin
            dr_cap_s   = {{(DMI_W-32){1'b0}}, IDCODE};
            dr_shift_s = {{(DMI_W-32){1'b0}}, tdi_s, dr_sr_q[31:1]};
         end
         IR_DTMCS: begin
            dr_cap_s   = {{(DMI_W-32){1'b0}}, dtmcs_s};
            dr_shift_s = {{(DMI_W-32){1'b0}}, tdi_s, dr_sr_q[31:1]};
         end
         IR_DMI: begin
            dr_cap_s   = {{DMI_ABITS{1'b0}}, rdata_q, dmi_status_s};
            dr_shift_s = {tdi_s, dr_sr_q[DMI_W-1:1]};
         end
         default: begin
            dr_cap_s   = {DMI_W{1'b0}};
            dr_shift_s = {{(DMI_W-1){1'b0}}, tdi_s};
         end
      endcase
   end

   // next-state logic: sync, TAP, shift registers, DMI handshake
   always_comb begin
      tck_sync_d  = {tck_sync_q[0], jtag_TCK};
      tms_sync_d  = {tms_sync_q[0], jtag_TMS};
      tdi_sync_d  = {tdi_sync_q[0], jtag_TDI};
      tck_prev_d  = tck_sync_q[1];
      state_d     = state_q;
      ir_sr_d     = ir_sr_q;
      ir_reg_d    = ir_reg_q;
      dr_sr_d     = dr_sr_q;
      tdo_d       = tdo_q;
      req_valid_d = req_valid_q;
      req_data_d  = req_data_q;
      rdata_d     = rdata_q;
      sticky_d    = sticky_q;
      outst_d     = outst_q;

      if (req_valid_q && dtm_req_ready) begin
         req_valid_d = 1'b0;
      end else begin
         req_valid_d = req_valid_q;
      end

      // response handled before any Update-DR in the same clk
      if (dm_resp_valid && outst_q) begin
         rdata_d = dm_resp_data;
         outst_d = 1'b0;
      end else begin
         rdata_d = rdata_q;
      end

      if (tck_rise_s) begin
         state_d = tap_next(state_q, tms_s);
         case (state_q)
            CAP_IR:   ir_sr_d  = 5'b00001;
            SHIFT_IR: ir_sr_d  = {tdi_s, ir_sr_q[4:1]};
            UPD_IR:   ir_reg_d = ir_sr_q;
            CAP_DR:   dr_sr_d  = dr_cap_s;
            SHIFT_DR: dr_sr_d  = dr_shift_s;
            UPD_DR: begin
               if (ir_reg_q == IR_DMI) begin
                  if (outst_d) begin
                     sticky_d = 2'b11;
                  end else if ((dr_sr_q[1:0] == 2'b01) || (dr_sr_q[1:0] == 2'b10)) begin
                     req_valid_d = 1'b1;
                     req_data_d  = dr_sr_q;
                     outst_d     = 1'b1;
                  end else begin
                     outst_d = outst_d;
                  end
               end else if (ir_reg_q == IR_DTMCS) begin
                  if (dr_sr_q[16] || dr_sr_q[17]) begin
                     sticky_d = 2'b00;
                  end else begin
                     sticky_d = sticky_q;
                  end
                  if (dr_sr_q[17]) begin
                     outst_d     = 1'b0;
                     req_valid_d = 1'b0;
                  end else begin
                     outst_d = outst_d;
                  end
               end else begin
                  sticky_d = sticky_q;
               end
            end
            default: ir_sr_d = ir_sr_q;
         endcase
      end else begin
         state_d = state_q;
      end

      if (tck_fall_s) begin
         if (state_q == SHIFT_IR) begin
            tdo_d = ir_sr_q[0];
         end else if (state_q == SHIFT_DR) begin
            tdo_d = dr_sr_q[0];
         end else begin
            tdo_d = tdo_q;
         end
      end else begin
         tdo_d = tdo_q;
      end

      if (state_q == TLR) begin
         ir_reg_d = IR_IDCODE;
         sticky_d = 2'b00;
      end else begin
         ir_reg_d = ir_reg_d;
      end
   end

   // state registers with synchronous active-low reset
   always_ff @(posedge clk) begin
      if (!rst) begin
         tck_sync_q  <= 2'b00;
         tms_sync_q  <= 2'b00;
         tdi_sync_q  <= 2'b00;
         tck_prev_q  <= 1'b0;
         state_q     <= TLR;
         ir_sr_q     <= 5'h00;
         ir_reg_q    <= IR_IDCODE;
         dr_sr_q     <= {DMI_W{1'b0}};
         tdo_q       <= 1'b0;
         req_valid_q <= 1'b0;
         req_data_q  <= {DMI_W{1'b0}};
         rdata_q     <= 32'h0;
         sticky_q    <= 2'b00;
         outst_q     <= 1'b0;
      end else begin
         tck_sync_q  <= tck_sync_d;
         tms_sync_q  <= tms_sync_d;
         tdi_sync_q  <= tdi_sync_d;
         tck_prev_q  <= tck_prev_d;
         state_q     <= state_d;
         ir_sr_q     <= ir_sr_d;
         ir_reg_q    <= ir_reg_d;
         dr_sr_q     <= dr_sr_d;
         tdo_q       <= tdo_d;
         req_valid_q <= req_valid_d;
         req_data_q  <= req_data_d;
         rdata_q     <= rdata_d;
         sticky_q    <= sticky_d;
         outst_q     <= outst_d;
      end
   end

   assign jtag_TDO      = tdo_q;
   assign ir_reg        = ir_reg_q;
   assign dtm_req_valid = req_valid_q;
   assign dtm_req_data  = req_data_q;

endmodule

// File: tb/tb_jtag_dtm_sampled.sv
// Scoreboard bench for jtag_dtm_sampled: the stimulus thread pushes expected
// values, monitor processes pop and compare when the DUT presents results.
module tb_jtag_dtm_sampled;

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic        jtag_TCK = 1'b0;
   logic        jtag_TMS = 1'b0;
   logic        jtag_TDI = 1'b0;
   logic        jtag_TDO;
   logic [4:0]  ir_reg;
   logic        dtm_req_valid;
   logic [39:0] dtm_req_data;
   logic        dtm_req_ready = 1'b0;
   logic        dm_resp_valid = 1'b0;
   logic [31:0] dm_resp_data = 32'h0;

   jtag_dtm_sampled dut (
      .clk(clk), .rst(rst),
      .jtag_TCK(jtag_TCK), .jtag_TMS(jtag_TMS), .jtag_TDI(jtag_TDI), .jtag_TDO(jtag_TDO),
      .ir_reg(ir_reg),
      .dtm_req_valid(dtm_req_valid), .dtm_req_data(dtm_req_data), .dtm_req_ready(dtm_req_ready),
      .dm_resp_valid(dm_resp_valid), .dm_resp_data(dm_resp_data)
   );

   always #5 clk = ~clk;

   int total = 0;
   int bad = 0;
   int req_cnt = 0;

   string       exp_name_q[$];
   logic [63:0] exp_val_q[$];
   logic [63:0] obs_val_q[$];
   logic [39:0] exp_req_q[$];

   task automatic expect_val(input string name, input logic [63:0] v);
      exp_name_q.push_back(name);
      exp_val_q.push_back(v);
   endtask

   task automatic observe(input logic [63:0] v);
      obs_val_q.push_back(v);
   endtask

   // value scoreboard
   always @(negedge clk) begin
      string       n;
      logic [63:0] e;
      logic [63:0] a;
      #1;
      while (exp_val_q.size() > 0 && obs_val_q.size() > 0) begin
         n = exp_name_q.pop_front();
         e = exp_val_q.pop_front();
         a = obs_val_q.pop_front();
         total++;
         if (a !== e) begin
            bad++;
            $display("FAIL %s: got %h want %h", n, a, e);
         end
      end
   end

   // DMI request monitor: new requests against expected queue, hold while stalled
   logic        prev_v = 1'b0;
   logic        prev_r = 1'b0;
   logic [39:0] prev_d = 40'h0;
   always @(negedge clk) begin
      logic [39:0] e;
      #1;
      if (rst) begin
         if (dtm_req_valid && !prev_v) begin
            req_cnt++;
            total++;
            if (exp_req_q.size() == 0) begin
               bad++;
               $display("FAIL unexpected_req: got %h want none", dtm_req_data);
            end else begin
               e = exp_req_q.pop_front();
               if (dtm_req_data !== e) begin
                  bad++;
                  $display("FAIL req_data: got %h want %h", dtm_req_data, e);
               end
            end
         end
         if (prev_v && !prev_r) begin
            total++;
            if (!dtm_req_valid || dtm_req_data !== prev_d) begin
               bad++;
               $display("FAIL req_hold: got v=%b d=%h want v=1 d=%h", dtm_req_valid, dtm_req_data, prev_d);
            end
         end
      end
      prev_v = dtm_req_valid;
      prev_r = dtm_req_ready;
      prev_d = dtm_req_data;
   end

   // one TCK cycle; returns TDO as seen just before the rise
   task automatic pulse(input logic tms, input logic tdi, output logic tdo);
      tdo = jtag_TDO;
      jtag_TMS = tms;
      jtag_TDI = tdi;
      jtag_TCK = 1'b1;
      repeat (5) @(negedge clk);
      jtag_TCK = 1'b0;
      repeat (5) @(negedge clk);
   endtask

   // RTI -> DR scan of n bits -> Update-DR -> RTI
   task automatic shift_dr(input int n, input logic [63:0] din, output logic [63:0] dout);
      logic t;
      dout = 64'h0;
      pulse(1'b1, 1'b0, t);
      pulse(1'b0, 1'b0, t);
      pulse(1'b0, 1'b0, t);
      for (int i = 0; i < n; i++) begin
         pulse(i == n - 1, din[i], t);
         dout[i] = t;
      end
      pulse(1'b1, 1'b0, t);
      pulse(1'b0, 1'b0, t);
   endtask

   // RTI -> IR scan -> Update-IR -> RTI
   task automatic shift_ir(input logic [4:0] din, output logic [4:0] dout);
      logic t;
      dout = 5'h0;
      pulse(1'b1, 1'b0, t);
      pulse(1'b1, 1'b0, t);
      pulse(1'b0, 1'b0, t);
      pulse(1'b0, 1'b0, t);
      for (int i = 0; i < 5; i++) begin
         pulse(i == 4, din[i], t);
         dout[i] = t;
      end
      pulse(1'b1, 1'b0, t);
      pulse(1'b0, 1'b0, t);
   endtask

   task automatic resp(input logic [31:0] d);
      dm_resp_valid = 1'b1;
      dm_resp_data  = d;
      @(negedge clk);
      dm_resp_valid = 1'b0;
      @(negedge clk);
   endtask

   initial begin
      logic [63:0] d;
      logic [4:0]  irq;
      logic        t;
      logic [39:0] wr;

      rst = 1'b0;
      repeat (4) @(negedge clk);
      expect_val("rst_ir", 64'h01);       observe(64'(ir_reg));
      expect_val("rst_tdo", 64'h0);       observe(64'(jtag_TDO));
      expect_val("rst_valid", 64'h0);     observe(64'(dtm_req_valid));
      expect_val("rst_data", 64'h0);      observe(64'(dtm_req_data));
      rst = 1'b1;
      repeat (2) @(negedge clk);

      for (int i = 0; i < 8; i++) pulse(1'b1, 1'b0, t);
      expect_val("tlr_ir", 64'h01);       observe(64'(ir_reg));
      expect_val("tlr_valid", 64'h0);     observe(64'(dtm_req_valid));
      pulse(1'b0, 1'b0, t);

      expect_val("idcode", 64'h1E200A6D);
      shift_dr(32, 64'h0, d);             observe(d);

      expect_val("ircap_dtmcs", 64'h01);
      shift_ir(5'h10, irq);               observe(64'(irq));
      expect_val("ir_dtmcs", 64'h10);     observe(64'(ir_reg));
      expect_val("dtmcs_cap", 64'h5061);
      shift_dr(32, 64'h0, d);             observe(d);

      expect_val("ircap_dmi", 64'h01);
      shift_ir(5'h11, irq);               observe(64'(irq));
      expect_val("ir_dmi", 64'h11);       observe(64'(ir_reg));

      // write addr 0x10, stalled by ready=0
      exp_req_q.push_back(40'h40_0000_0002);
      expect_val("dmi_cap0", 64'h0);
      shift_dr(40, 64'h40_0000_0002, d);  observe(d);
      repeat (10) @(negedge clk);
      expect_val("stall_valid", 64'h1);   observe(64'(dtm_req_valid));
      expect_val("stall_data", 64'h40_0000_0002); observe(64'(dtm_req_data));
      dtm_req_ready = 1'b1;
      @(negedge clk);
      dtm_req_ready = 1'b0;
      @(negedge clk);
      expect_val("accepted_valid", 64'h0); observe(64'(dtm_req_valid));
      resp(32'h12345678);

      expect_val("dmi_cap_rdata", 64'h00_48D1_59E0);
      shift_dr(40, 64'h0, d);             observe(d);

      // read op=01, accepted at once, response withheld
      dtm_req_ready = 1'b1;
      exp_req_q.push_back(40'h14_0000_0001);
      expect_val("dmi_cap_rd", 64'h00_48D1_59E0);
      shift_dr(40, 64'h14_0000_0001, d);  observe(d);

      // write while read outstanding: dropped, sticky set
      wr = {6'h10, 32'hCAFEF00D, 2'b10};
      expect_val("dmi_cap_busy", 64'h00_48D1_59E3);
      shift_dr(40, 64'(wr), d);           observe(d);
      expect_val("dmi_cap_sticky", 64'h00_48D1_59E3);
      shift_dr(40, 64'h0, d);             observe(d);

      // dmireset, then the response arrives
      shift_ir(5'h10, irq);
      expect_val("dtmcs_sticky", 64'h5C61);
      shift_dr(32, 64'h0001_0000, d);     observe(d);
      resp(32'hDEADBEEF);
      shift_ir(5'h11, irq);
      expect_val("dmi_cap_dead", 64'h03_7AB6_FBBC);
      shift_dr(40, 64'h0, d);             observe(d);

      // reset in the middle of a DMI write scan
      wr = 40'h40_0000_0002;
      pulse(1'b1, 1'b0, t);
      pulse(1'b0, 1'b0, t);
      pulse(1'b0, 1'b0, t);
      for (int i = 0; i < 20; i++) pulse(1'b0, wr[i], t);
      rst = 1'b0;
      repeat (3) @(negedge clk);
      rst = 1'b1;
      repeat (50) @(negedge clk);
      expect_val("midrst_valid", 64'h0);  observe(64'(dtm_req_valid));
      expect_val("midrst_ir", 64'h01);    observe(64'(ir_reg));
      expect_val("midrst_tdo", 64'h0);    observe(64'(jtag_TDO));
      pulse(1'b0, 1'b0, t);
      expect_val("idcode_again", 64'h1E200A6D);
      shift_dr(32, 64'h0, d);             observe(d);

      repeat (20) @(negedge clk);
      expect_val("req_count", 64'd2);     observe(64'(req_cnt));
      expect_val("req_left", 64'd0);      observe(64'(exp_req_q.size()));

      for (int i = 0; i < 100 && (exp_val_q.size() != 0 || obs_val_q.size() != 0); i++)
         @(negedge clk);
      @(negedge clk);
      if (exp_val_q.size() != 0 || obs_val_q.size() != 0) begin
         total++;
         bad++;
         $display("FAIL sb_drain: got exp=%0d obs=%0d left want 0", exp_val_q.size(), obs_val_q.size());
      end
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
